// File: rtl/pipeline_cpu.sv
// pipeline_cpu: five-stage in-order RV32I integer core (IF/ID/EX/MEM/WB).
// Instruction and data memories live outside; this block only drives the
// fetch PC and the MEM-stage access signals, and takes back the fetched
// word and the already-extended load data combinationally.
module pipeline_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_in,
    input  logic [31:0] Data_in,
    input  logic [4:0]  reg_sel,
    output logic [31:0] PC_out,
    output logic [31:0] Addr_out,
    output logic [31:0] Data_out,
    output logic        mem_w,
    output logic [2:0]  DMType_out,
    output logic [31:0] debug_data,
    output logic [31:0] reg_data
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF_S = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE_S = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    typedef struct packed {
        logic       reg_w;
        logic       mem_r;
        logic       mem_w;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       a_pc;
        logic       a_zero;
        logic       b_imm;
        alu_op_t    alu_op;
        logic [2:0] br_f3;
        logic [2:0] dm_type;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // architectural state
    logic [31:0] pc;
    logic [31:0] regs [32];

    // IF/ID
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;

    // ID/EX
    ctrl_t       idex_ctrl;
    logic [31:0] idex_pc;
    logic [31:0] idex_rd1;
    logic [31:0] idex_rd2;
    logic [31:0] idex_imm;
    logic [4:0]  idex_rs1;
    logic [4:0]  idex_rs2;
    logic [4:0]  idex_rd;

    // EX/MEM
    logic        exmem_reg_w;
    logic        exmem_mem_r;
    logic        exmem_mem_w;
    logic [2:0]  exmem_dm_type;
    logic [31:0] exmem_result;
    logic [31:0] exmem_rs2;
    logic [4:0]  exmem_rd;

    // MEM/WB
    logic        memwb_reg_w;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;

    logic        wb_we;

    // ID decode fields
    logic [6:0]  id_opcode;
    logic [2:0]  id_f3;
    logic [6:0]  id_f7;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    ctrl_t       id_ctrl;
    logic [31:0] id_imm;
    logic        id_valid;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;

    // EX signals
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic        br_cond;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic [31:0] ex_result;

    logic        load_use;

    function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel = ALU_SLL;
            3'b010:  alu_sel = ALU_SLT;
            3'b011:  alu_sel = ALU_SLTU;
            3'b100:  alu_sel = ALU_XOR;
            3'b101:  alu_sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel = ALU_OR;
            default: alu_sel = ALU_AND;
        endcase
    endfunction

    assign id_opcode = ifid_instr[6:0];
    assign id_rd     = ifid_instr[11:7];
    assign id_f3     = ifid_instr[14:12];
    assign id_rs1    = ifid_instr[19:15];
    assign id_rs2    = ifid_instr[24:20];
    assign id_f7     = ifid_instr[31:25];

    assign imm_i = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
    assign imm_s = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
    assign imm_b = {{20{ifid_instr[31]}}, ifid_instr[7], ifid_instr[30:25],
                    ifid_instr[11:8], 1'b0};
    assign imm_u = {ifid_instr[31:12], 12'b0};
    assign imm_j = {{12{ifid_instr[31]}}, ifid_instr[19:12], ifid_instr[20],
                    ifid_instr[30:21], 1'b0};

    // Decode the IF/ID word into EX controls; unknown encodings become bubbles.
    always_comb begin
        id_ctrl  = CTRL_NOP;
        id_imm   = '0;
        id_valid = 1'b0;
        case (id_opcode)
            OP_LUI: begin
                id_valid       = 1'b1;
                id_ctrl.reg_w  = 1'b1;
                id_ctrl.a_zero = 1'b1;
                id_ctrl.b_imm  = 1'b1;
                id_imm         = imm_u;
            end
            OP_AUIPC: begin
                id_valid      = 1'b1;
                id_ctrl.reg_w = 1'b1;
                id_ctrl.a_pc  = 1'b1;
                id_ctrl.b_imm = 1'b1;
                id_imm        = imm_u;
            end
            OP_JAL: begin
                id_valid      = 1'b1;
                id_ctrl.reg_w = 1'b1;
                id_ctrl.jal   = 1'b1;
                id_imm        = imm_j;
            end
            OP_JALR: begin
                id_valid      = (id_f3 == 3'b000);
                id_ctrl.reg_w = 1'b1;
                id_ctrl.jalr  = 1'b1;
                id_imm        = imm_i;
            end
            OP_BRANCH: begin
                id_valid       = (id_f3 != 3'b010) && (id_f3 != 3'b011);
                id_ctrl.branch = 1'b1;
                id_ctrl.br_f3  = id_f3;
                id_imm         = imm_b;
            end
            OP_LOAD: begin
                id_valid      = 1'b1;
                id_ctrl.reg_w = 1'b1;
                id_ctrl.mem_r = 1'b1;
                id_ctrl.b_imm = 1'b1;
                id_imm        = imm_i;
                case (id_f3)
                    3'b000:  id_ctrl.dm_type = DM_BYTE_S;
                    3'b001:  id_ctrl.dm_type = DM_HALF_S;
                    3'b010:  id_ctrl.dm_type = DM_WORD;
                    3'b100:  id_ctrl.dm_type = DM_BYTE_U;
                    3'b101:  id_ctrl.dm_type = DM_HALF_U;
                    default: id_valid = 1'b0;
                endcase
            end
            OP_STORE: begin
                id_valid      = 1'b1;
                id_ctrl.mem_w = 1'b1;
                id_ctrl.b_imm = 1'b1;
                id_imm        = imm_s;
                case (id_f3)
                    3'b000:  id_ctrl.dm_type = DM_BYTE_S;
                    3'b001:  id_ctrl.dm_type = DM_HALF_S;
                    3'b010:  id_ctrl.dm_type = DM_WORD;
                    default: id_valid = 1'b0;
                endcase
            end
            OP_IMM: begin
                id_ctrl.reg_w  = 1'b1;
                id_ctrl.b_imm  = 1'b1;
                id_imm         = imm_i;
                id_ctrl.alu_op = alu_sel(id_f3, (id_f3 == 3'b101) && id_f7[5]);
                case (id_f3)
                    3'b001:  id_valid = (id_f7 == 7'b0000000);
                    3'b101:  id_valid = (id_f7 == 7'b0000000) || (id_f7 == 7'b0100000);
                    default: id_valid = 1'b1;
                endcase
            end
            OP_REG: begin
                id_ctrl.reg_w  = 1'b1;
                id_ctrl.alu_op = alu_sel(id_f3, id_f7[5]);
                id_valid = (id_f7 == 7'b0000000) ||
                           ((id_f7 == 7'b0100000) && ((id_f3 == 3'b000) || (id_f3 == 3'b101)));
            end
            default: id_valid = 1'b0;
        endcase
        if (!id_valid) begin
            id_ctrl = CTRL_NOP;
        end
        if (id_rd == 5'd0) begin
            id_ctrl.reg_w = 1'b0;
        end
    end

    assign wb_we = memwb_reg_w && (memwb_rd != 5'd0);

    // Register-file read with write-first bypass from the WB stage.
    always_comb begin
        id_rd1 = regs[id_rs1];
        id_rd2 = regs[id_rs2];
        if (wb_we && (memwb_rd == id_rs1)) id_rd1 = memwb_result;
        if (wb_we && (memwb_rd == id_rs2)) id_rd2 = memwb_result;
        if (id_rs1 == 5'd0) id_rd1 = '0;
        if (id_rs2 == 5'd0) id_rd2 = '0;
    end

    // A load result is only available from MEM/WB, so a consumer directly behind it waits one cycle.
    assign load_use = idex_ctrl.mem_r && (idex_rd != 5'd0) &&
                      ((idex_rd == id_rs1) || (idex_rd == id_rs2));

    // Operand forwarding: EX/MEM beats MEM/WB, x0 never forwarded.
    always_comb begin
        fwd_a = idex_rd1;
        fwd_b = idex_rd2;
        if ((idex_rs1 != 5'd0) && exmem_reg_w && !exmem_mem_r && (exmem_rd == idex_rs1))
            fwd_a = exmem_result;
        else if ((idex_rs1 != 5'd0) && wb_we && (memwb_rd == idex_rs1))
            fwd_a = memwb_result;
        if ((idex_rs2 != 5'd0) && exmem_reg_w && !exmem_mem_r && (exmem_rd == idex_rs2))
            fwd_b = exmem_result;
        else if ((idex_rs2 != 5'd0) && wb_we && (memwb_rd == idex_rs2))
            fwd_b = memwb_result;
    end

    assign op_a = idex_ctrl.a_zero ? 32'd0 : (idex_ctrl.a_pc ? idex_pc : fwd_a);
    assign op_b = idex_ctrl.b_imm ? idex_imm : fwd_b;

    // ALU.
    always_comb begin
        case (idex_ctrl.alu_op)
            ALU_ADD:  alu_out = op_a + op_b;
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_SLL:  alu_out = op_a << op_b[4:0];
            ALU_SLT:  alu_out = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_out = {31'b0, op_a < op_b};
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_SRL:  alu_out = op_a >> op_b[4:0];
            ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:   alu_out = op_a | op_b;
            default:  alu_out = op_a & op_b;
        endcase
    end

    // Branch condition on the forwarded register operands.
    always_comb begin
        case (idex_ctrl.br_f3)
            3'b000:  br_cond = (fwd_a == fwd_b);
            3'b001:  br_cond = (fwd_a != fwd_b);
            3'b100:  br_cond = ($signed(fwd_a) < $signed(fwd_b));
            3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  br_cond = (fwd_a < fwd_b);
            3'b111:  br_cond = (fwd_a >= fwd_b);
            default: br_cond = 1'b0;
        endcase
    end

    assign ex_taken  = idex_ctrl.jal || idex_ctrl.jalr || (idex_ctrl.branch && br_cond);
    assign ex_target = idex_ctrl.jalr ? ((fwd_a + idex_imm) & ~32'd1) : (idex_pc + idex_imm);
    assign ex_result = (idex_ctrl.jal || idex_ctrl.jalr) ? (idex_pc + 32'd4) : alu_out;

    // PC: redirect beats stall, otherwise advance by one word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           pc <= RESET_PC;
        else if (ex_taken)  pc <= ex_target;
        else if (!load_use) pc <= pc + 32'd4;
    end

    // IF/ID: flushed on redirect, held on load-use stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= RESET_PC;
        end else if (ex_taken) begin
            ifid_instr <= NOP_INSTR;
        end else if (!load_use) begin
            ifid_instr <= instr_in;
            ifid_pc    <= pc;
        end
    end

    // ID/EX: bubble on redirect or load-use stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_ctrl <= CTRL_NOP;
            idex_pc   <= '0;
            idex_rd1  <= '0;
            idex_rd2  <= '0;
            idex_imm  <= '0;
            idex_rs1  <= '0;
            idex_rs2  <= '0;
            idex_rd   <= '0;
        end else if (ex_taken || load_use) begin
            idex_ctrl <= CTRL_NOP;
            idex_rs1  <= '0;
            idex_rs2  <= '0;
            idex_rd   <= '0;
        end else begin
            idex_ctrl <= id_ctrl;
            idex_pc   <= ifid_pc;
            idex_rd1  <= id_rd1;
            idex_rd2  <= id_rd2;
            idex_imm  <= id_imm;
            idex_rs1  <= id_rs1;
            idex_rs2  <= id_rs2;
            idex_rd   <= id_rd;
        end
    end

    // EX/MEM: always advances.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exmem_reg_w   <= 1'b0;
            exmem_mem_r   <= 1'b0;
            exmem_mem_w   <= 1'b0;
            exmem_dm_type <= DM_WORD;
            exmem_result  <= '0;
            exmem_rs2     <= '0;
            exmem_rd      <= '0;
        end else begin
            exmem_reg_w   <= idex_ctrl.reg_w;
            exmem_mem_r   <= idex_ctrl.mem_r;
            exmem_mem_w   <= idex_ctrl.mem_w;
            exmem_dm_type <= idex_ctrl.dm_type;
            exmem_result  <= ex_result;
            exmem_rs2     <= fwd_b;
            exmem_rd      <= idex_rd;
        end
    end

    // MEM/WB: loads take the memory's data as-is, everything else the ALU/link value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memwb_reg_w  <= 1'b0;
            memwb_rd     <= '0;
            memwb_result <= '0;
        end else begin
            memwb_reg_w  <= exmem_reg_w;
            memwb_rd     <= exmem_rd;
            memwb_result <= exmem_mem_r ? Data_in : exmem_result;
        end
    end

    // Register file write port; x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_we) begin
            regs[memwb_rd] <= memwb_result;
        end
    end

    assign PC_out     = pc;
    assign Addr_out   = exmem_result;
    assign Data_out   = exmem_rs2;
    assign mem_w      = exmem_mem_w;
    assign DMType_out = exmem_dm_type;
    assign debug_data = wb_we ? memwb_result : 32'd0;
    assign reg_data   = (reg_sel == 5'd0) ? 32'd0 : regs[reg_sel];

endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed bench for pipeline_cpu: small program in a bench-side instruction
// memory, fixed load data, per-cycle PC/store checks and final register state.
module tb_pipeline_cpu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] instr_in;
    logic [31:0] Data_in;
    logic [4:0]  reg_sel;
    logic [31:0] PC_out;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        mem_w;
    logic [2:0]  DMType_out;
    logic [31:0] debug_data;
    logic [31:0] reg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] prog [16];
    logic [31:0] pc_exp [13] = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C,
                                 32'h1C, 32'h20, 32'h24, 32'h28, 32'h28, 32'h2C};

    pipeline_cpu #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_in   (instr_in),
        .Data_in    (Data_in),
        .reg_sel    (reg_sel),
        .PC_out     (PC_out),
        .Addr_out   (Addr_out),
        .Data_out   (Data_out),
        .mem_w      (mem_w),
        .DMType_out (DMType_out),
        .debug_data (debug_data),
        .reg_data   (reg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory for the first 16 words, NOP elsewhere.
    always_comb begin
        if (PC_out[31:6] == 26'd0) instr_in = prog[PC_out[5:2]];
        else                       instr_in = NOP;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input logic [4:0] idx, input logic [31:0] exp);
        reg_sel = idx;
        #1;
        check_val($sformatf("x%0d", idx), reg_data, exp);
    endtask

    initial begin
        rst     = 1'b0;
        reg_sel = 5'd0;
        Data_in = 32'h0000_1234;
        for (int i = 0; i < 16; i++) prog[i] = NOP;
        prog[0]  = 32'h8765_47B7;  // lui  x15,0x87654
        prog[1]  = 32'h3217_8793;  // addi x15,x15,0x321
        prog[2]  = 32'h00F0_0213;  // addi x4,x0,15
        prog[3]  = 32'h0047_F3B3;  // and  x7,x15,x4
        prog[4]  = 32'h00F7_F393;  // andi x7,x15,15
        prog[5]  = 32'h0000_2283;  // lw   x5,0(x0)
        prog[6]  = 32'h0012_8313;  // addi x6,x5,1
        prog[7]  = 32'h0040_2423;  // sw   x4,8(x0)
        prog[8]  = 32'h0000_0463;  // beq  x0,x0,+8
        prog[9]  = 32'h0050_0413;  // addi x8,x0,5   (flushed)
        prog[10] = 32'h0014_8493;  // addi x9,x9,1   (target; must run once)

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_pc",     PC_out, 32'h0);
        check_val("rst_memw",   {31'b0, mem_w}, 32'h0);
        check_val("rst_addr",   Addr_out, 32'h0);
        check_val("rst_data",   Data_out, 32'h0);
        check_val("rst_dmtype", {29'b0, DMType_out}, 32'h0);
        check_val("rst_debug",  debug_data, 32'h0);
        check_reg(5'd1, 32'h0);
        rst = 1'b1;

        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (e <= 13) check_val($sformatf("pc_e%0d", e), PC_out, pc_exp[e-1]);
            check_val($sformatf("memw_e%0d", e), {31'b0, mem_w}, (e == 11) ? 32'd1 : 32'd0);
            if (e == 1) check_val("debug_e1", debug_data, 32'h0);
            if (e == 4) check_val("debug_lui", debug_data, 32'h8765_4000);
            if (e == 5) check_reg(5'd15, 32'h8765_4000);
            if (e == 11) begin
                check_val("st_addr",   Addr_out, 32'h0000_0008);
                check_val("st_data",   Data_out, 32'h0000_000F);
                check_val("st_dmtype", {29'b0, DMType_out}, 32'h0);
            end
        end

        check_reg(5'd15, 32'h8765_4321);
        check_reg(5'd4,  32'h0000_000F);
        check_reg(5'd7,  32'h0000_0001);
        check_reg(5'd5,  32'h0000_1234);
        check_reg(5'd6,  32'h0000_1235);
        check_reg(5'd8,  32'h0000_0000);
        check_reg(5'd9,  32'h0000_0001);
        check_reg(5'd0,  32'h0000_0000);

        // Second run: assert reset asynchronously while the store sits in MEM.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk);
            #1;
        end
        check_val("r2_memw_pre", {31'b0, mem_w}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("async_pc",   PC_out, 32'h0);
        check_val("async_memw", {31'b0, mem_w}, 32'd0);
        check_val("async_addr", Addr_out, 32'h0);
        check_val("async_dbg",  debug_data, 32'h0);
        check_reg(5'd4,  32'h0);
        check_reg(5'd15, 32'h0);
        check_reg(5'd5,  32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
